// File: rtl/matrix_pkg.sv
// Shared types and helpers for the dot-matrix picture source.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package matrix_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_WARN   = 2'd2,
    MODE_ALARM  = 2'd3
  } mode_e;

  localparam logic [7:0] WAVE_EVEN = 8'hAA;
  localparam logic [7:0] WAVE_ODD  = 8'h55;
  localparam logic [3:0] MAX_LEVEL = 4'd8;

  // Clamp a raw fill level into 0..MAX_LEVEL.
  function automatic logic [3:0] sat_level(input logic [3:0] lvl);
    return (lvl > MAX_LEVEL) ? MAX_LEVEL : lvl;
  endfunction

  // Solid bar: the bottom Ls rows (highest bytes) set to all-ones.
  function automatic logic [63:0] bar_mask(input logic [3:0] lvl);
    logic [3:0] ls;
    logic [6:0] sh;
    ls = sat_level(lvl);
    sh = 7'd64 - {ls, 3'b000};
    if (ls == 4'd0) return 64'd0;
    return {64{1'b1}} << sh;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle step strobe every TICK_DIV cycles.
// Latency: first step on the TICK_DIV-th rising edge after reset release.
// Backpressure: none; free-running. Ports: clk, rst_n in; step out.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000,
  parameter int CNT_W    = $clog2(TICK_DIV) + 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic step
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // step is combinational so the consumer sees it on the same edge the
  // counter wraps; with TICK_DIV = 1 cnt sits at 0 and step is always high.
  assign step = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/matrix_pattern_gen.sv
// Animated 8x8 red/green picture source: water-level bar with a wave crest.
// Latency: pictures and frame_tick update on the step edge, held until next step.
// Backpressure: none; the scanner just reads a frame that is stable between steps.
// Ports: clk, rst_n; level[3:0] (saturates at 8), mode[1:0];
//        picture_r/picture_g[63:0] (byte k = row k, row 0 top); frame_tick.
module matrix_pattern_gen
  import matrix_pkg::*;
#(
  parameter int TICK_DIV = 25_000,
  parameter int CNT_W    = $clog2(TICK_DIV) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  level,
  input  logic [1:0]  mode,
  output logic [63:0] picture_r,
  output logic [63:0] picture_g,
  output logic        frame_tick
);

  logic        step;
  mode_e       mode_in;
  mode_e       mode_q;
  mode_e       mode_nxt;
  logic [2:0]  phase_q;
  logic [2:0]  phase_nxt;
  logic [2:0]  phase_use;
  logic [3:0]  ls;
  logic [2:0]  row_idx;
  logic [63:0] mask;
  logic [63:0] wavebar;
  logic [63:0] pic_r_nxt;
  logic [63:0] pic_g_nxt;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step)
  );

  always_comb begin
    mode_in   = mode_e'(mode);
    ls        = sat_level(level);
    mask      = bar_mask(level);
    // A mode change restarts the animation from phase 0.
    phase_use = (mode_in != mode_q) ? 3'd0 : phase_q;
    // Top lit row sits at byte 8-Ls; truncation of 8 for Ls=0 is harmless
    // because the crest is only inserted when the bar is non-empty.
    row_idx   = 3'(MAX_LEVEL - ls);

    wavebar = mask;
    if (ls != 4'd0) begin
      wavebar[{row_idx, 3'b000} +: 8] = phase_use[0] ? WAVE_ODD : WAVE_EVEN;
    end

    pic_r_nxt = 64'd0;
    pic_g_nxt = 64'd0;
    case (mode_in)
      MODE_NORMAL: pic_g_nxt = wavebar;
      MODE_WARN: begin
        pic_r_nxt = wavebar;
        pic_g_nxt = wavebar;
      end
      MODE_ALARM:  pic_r_nxt = phase_use[0] ? 64'd0 : mask;
      default: ;
    endcase

    mode_nxt  = mode_q;
    phase_nxt = phase_q;
    if (step) begin
      mode_nxt  = mode_in;
      phase_nxt = phase_use + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_OFF;
      phase_q    <= 3'd0;
      picture_r  <= 64'd0;
      picture_g  <= 64'd0;
      frame_tick <= 1'b0;
    end else begin
      mode_q     <= mode_nxt;
      phase_q    <= phase_nxt;
      frame_tick <= step;
      if (step) begin
        picture_r <= pic_r_nxt;
        picture_g <= pic_g_nxt;
      end
    end
  end

endmodule
